// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline hazard/stall controller.
// State encoding and the architectural register-zero number live here so the
// controller, its comparator and any checker agree on them.
package pipe_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } pipe_state_t;

  // Register $0 is hard-wired to zero, so it never carries a true dependency.
  localparam logic [4:0] REG_ZERO = 5'd0;

  // Width of the memory wait counter.
  localparam int CNT_W = 8;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Control bundle between the pipeline datapath and pipe_ctrl.
// master : the datapath side (drives stage information, consumes enables).
// slave  : the controller side.
// Handshake: mem_req is the MEM stage's valid and mem_ready is the memory's
// ready; a data access completes on the cycle where both are high, and while
// mem_req is high with mem_ready low the pipeline is frozen.
interface pipe_ctrl_if;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       ex_mem_read;
  logic [4:0] ex_rt;
  logic       id_branch_taken;
  logic       mem_req;
  logic       mem_ready;
  logic       pc_we;
  logic       if_id_we;
  logic       id_ex_we;
  logic       ex_mem_we;
  logic       if_id_flush;
  logic       id_ex_flush;
  logic       mem_wb_bubble;
  logic       mem_err;

  modport master (
    output id_rs, id_rt, ex_mem_read, ex_rt, id_branch_taken, mem_req, mem_ready,
    input  pc_we, if_id_we, id_ex_we, ex_mem_we,
    input  if_id_flush, id_ex_flush, mem_wb_bubble, mem_err
  );

  modport slave (
    input  id_rs, id_rt, ex_mem_read, ex_rt, id_branch_taken, mem_req, mem_ready,
    output pc_we, if_id_we, id_ex_we, ex_mem_we,
    output if_id_flush, id_ex_flush, mem_wb_bubble, mem_err
  );
endinterface

// File: rtl/hazard_detect.sv
// Load-use comparator: a load in EX whose destination is read by the
// instruction in ID. Purely combinational.
module hazard_detect
  import pipe_pkg::*;
(
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rt,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  output logic       load_use
);

  assign load_use = ex_mem_read && (ex_rt != REG_ZERO) &&
                    ((ex_rt == id_rs) || (ex_rt == id_rt));

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller (Mealy FSM: RUN, MEM_WAIT, ERROR).
// All state updates on the falling clock edge, matching the stage registers.
// Optional build macro PIPE_CTRL_PERF_EN adds the stall_cycles and
// flush_count performance counters.
module pipe_ctrl
  import pipe_pkg::*;
#(
  parameter int WAIT_MAX = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  pipe_ctrl_if.slave        pif,
  output pipe_state_t       state_dbg,
  output logic [CNT_W-1:0]  wait_cnt_dbg
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [31:0]       stall_cycles,
  output logic [31:0]       flush_count
`endif
);

  localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(WAIT_MAX);

  pipe_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  // Set for the cycle after a load-use stall: the load has advanced by then,
  // so the stall is never repeated for the same dependency.
  logic             lu_hold_q, lu_hold_d;
  logic             load_use;

  logic pc_we, if_id_we, id_ex_we, ex_mem_we;
  logic if_id_flush, id_ex_flush, mem_wb_bubble;

  hazard_detect u_hazard (
    .ex_mem_read (pif.ex_mem_read),
    .ex_rt       (pif.ex_rt),
    .id_rs       (pif.id_rs),
    .id_rt       (pif.id_rt),
    .load_use    (load_use)
  );

  // Next-state and Mealy outputs; reset overrides outputs to a full halt.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    err_d         = err_q;
    lu_hold_d     = 1'b0;
    pc_we         = 1'b1;
    if_id_we      = 1'b1;
    id_ex_we      = 1'b1;
    ex_mem_we     = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_flush   = 1'b0;
    mem_wb_bubble = 1'b0;

    case (state_q)
      RUN: begin
        if (pif.mem_req && !pif.mem_ready) begin
          // Memory wait wins: freeze everything, bubble into MEM/WB.
          pc_we         = 1'b0;
          if_id_we      = 1'b0;
          id_ex_we      = 1'b0;
          ex_mem_we     = 1'b0;
          mem_wb_bubble = 1'b1;
          state_d       = MEM_WAIT;
          cnt_d         = CNT_W'(1);
        end else if (load_use && !lu_hold_q) begin
          // Hold PC and IF/ID, push a bubble into ID/EX.
          pc_we       = 1'b0;
          if_id_we    = 1'b0;
          id_ex_flush = 1'b1;
          lu_hold_d   = 1'b1;
        end else if (pif.id_branch_taken) begin
          if_id_flush = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (pif.mem_ready) begin
          // Completion beats timeout, even on the last allowed cycle.
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          pc_we         = 1'b0;
          if_id_we      = 1'b0;
          id_ex_we      = 1'b0;
          ex_mem_we     = 1'b0;
          mem_wb_bubble = 1'b1;
          if (cnt_q == WAIT_LIMIT) begin
            state_d = ERROR;
            err_d   = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      ERROR: begin
        pc_we         = 1'b0;
        if_id_we      = 1'b0;
        id_ex_we      = 1'b0;
        ex_mem_we     = 1'b0;
        if_id_flush   = 1'b1;
        id_ex_flush   = 1'b1;
        mem_wb_bubble = 1'b1;
      end
      default: begin
        // Unused encoding: halt this cycle and recover to RUN.
        pc_we         = 1'b0;
        if_id_we      = 1'b0;
        id_ex_we      = 1'b0;
        ex_mem_we     = 1'b0;
        if_id_flush   = 1'b1;
        id_ex_flush   = 1'b1;
        mem_wb_bubble = 1'b1;
        state_d       = RUN;
        cnt_d         = '0;
      end
    endcase

    if (!rst_n) begin
      pc_we         = 1'b0;
      if_id_we      = 1'b0;
      id_ex_we      = 1'b0;
      ex_mem_we     = 1'b0;
      if_id_flush   = 1'b1;
      id_ex_flush   = 1'b1;
      mem_wb_bubble = 1'b1;
    end
  end

  // State, wait counter and sticky error register on the falling edge.
  always_ff @(negedge clk) begin
    if (!rst_n) begin
      state_q   <= RUN;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      lu_hold_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      lu_hold_q <= lu_hold_d;
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  // Free-running wrap-around counters of stalled and flushed cycles.
  always_ff @(negedge clk) begin
    if (!rst_n) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (!pc_we)      stall_cycles <= stall_cycles + 32'd1;
      if (if_id_flush) flush_count  <= flush_count + 32'd1;
    end
  end
`endif

  assign pif.pc_we         = pc_we;
  assign pif.if_id_we      = if_id_we;
  assign pif.id_ex_we      = id_ex_we;
  assign pif.ex_mem_we     = ex_mem_we;
  assign pif.if_id_flush   = if_id_flush;
  assign pif.id_ex_flush   = id_ex_flush;
  assign pif.mem_wb_bubble = mem_wb_bubble;
  assign pif.mem_err       = err_q;
  assign state_dbg         = state_q;
  assign wait_cnt_dbg      = cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl (WAIT_MAX=4). Inputs change just after the
// falling (active) edge; Mealy outputs are sampled at the rising edge and
// registered state just after the falling edge.
module tb_pipe_ctrl;
  import pipe_pkg::*;

  localparam int WAIT_MAX_TB = 4;

  // {pc_we, if_id_we, id_ex_we, ex_mem_we, if_id_flush, id_ex_flush, mem_wb_bubble}
  localparam logic [6:0] C_NORMAL = 7'b1111000;
  localparam logic [6:0] C_FREEZE = 7'b0000001;
  localparam logic [6:0] C_LU     = 7'b0011010;
  localparam logic [6:0] C_BRANCH = 7'b1111100;
  localparam logic [6:0] C_HALT   = 7'b0000111;

  logic        clk;
  logic        rst_n;
  pipe_state_t state_dbg;
  logic [7:0]  wait_cnt_dbg;
  logic [6:0]  ctl;
  int          checks;
  int          errors;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cycles;
  logic [31:0] flush_count;
`endif

  pipe_ctrl_if pif ();

  pipe_ctrl #(.WAIT_MAX(WAIT_MAX_TB)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pif          (pif),
    .state_dbg    (state_dbg),
    .wait_cnt_dbg (wait_cnt_dbg)
`ifdef PIPE_CTRL_PERF_EN
    ,
    .stall_cycles (stall_cycles),
    .flush_count  (flush_count)
`endif
  );

  assign ctl = {pif.pc_we, pif.if_id_we, pif.id_ex_we, pif.ex_mem_we,
                pif.if_id_flush, pif.id_ex_flush, pif.mem_wb_bubble};

  // Clock and watchdog
  initial begin
    clk = 1'b1;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  // Driver tasks
  task automatic set_in(input logic mr, input logic [4:0] ert, input logic [4:0] rs,
                        input logic [4:0] rt, input logic br, input logic rq,
                        input logic rdy);
    pif.ex_mem_read     = mr;
    pif.ex_rt           = ert;
    pif.id_rs           = rs;
    pif.id_rt           = rt;
    pif.id_branch_taken = br;
    pif.mem_req         = rq;
    pif.mem_ready       = rdy;
  endtask

  task automatic idle();
    set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic next_cycle();
    @(negedge clk);
    #1;
  endtask

  task automatic reset_dut();
    idle();
    rst_n = 1'b0;
    next_cycle();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    set_in(1'b1, 5'd8, 5'd8, 5'd0, 1'b1, 1'b1, 1'b0);
    @(posedge clk);
    checks++;
    if (ctl !== C_HALT) begin
      errors++; $display("FAIL reset_outputs: got %b expected %b", ctl, C_HALT);
    end
    next_cycle();
    checks++;
    if (state_dbg !== RUN || wait_cnt_dbg !== 8'd0 || pif.mem_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got state %0d cnt %0d err %b expected 0 0 0",
               state_dbg, wait_cnt_dbg, pif.mem_err);
    end
`ifdef PIPE_CTRL_PERF_EN
    checks++;
    if (stall_cycles !== 32'd0 || flush_count !== 32'd0) begin
      errors++; $display("FAIL reset_perf: got %0d %0d expected 0 0", stall_cycles, flush_count);
    end
`endif
    rst_n = 1'b1;
    idle();
    @(posedge clk);
    checks++;
    if (ctl !== C_NORMAL) begin
      errors++; $display("FAIL run_idle: got %b expected %b", ctl, C_NORMAL);
    end
    next_cycle();
  endtask

  task automatic test_load_use();
    // rs match, inputs held across two cycles
    set_in(1'b1, 5'd8, 5'd8, 5'd3, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    checks++;
    if (ctl !== C_LU) begin
      errors++; $display("FAIL load_use_rs: got %b expected %b", ctl, C_LU);
    end
    next_cycle();
    checks++;
    if (state_dbg !== RUN) begin
      errors++; $display("FAIL load_use_state: got %0d expected 0", state_dbg);
    end
    @(posedge clk);
    checks++;
    if (ctl !== C_NORMAL) begin
      errors++; $display("FAIL load_use_after: got %b expected %b", ctl, C_NORMAL);
    end
    next_cycle();
    idle();
    next_cycle();
    // rt match
    set_in(1'b1, 5'd17, 5'd2, 5'd17, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    checks++;
    if (ctl !== C_LU) begin
      errors++; $display("FAIL load_use_rt: got %b expected %b", ctl, C_LU);
    end
    next_cycle();
    idle();
    next_cycle();
  endtask

  task automatic test_no_hazard();
    // Register zero never stalls
    set_in(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    checks++;
    if (ctl !== C_NORMAL) begin
      errors++; $display("FAIL reg_zero: got %b expected %b", ctl, C_NORMAL);
    end
    next_cycle();
    // Matching register but not a load
    set_in(1'b0, 5'd9, 5'd9, 5'd9, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    checks++;
    if (ctl !== C_NORMAL) begin
      errors++; $display("FAIL not_load: got %b expected %b", ctl, C_NORMAL);
    end
    next_cycle();
    // Load with a different destination
    set_in(1'b1, 5'd9, 5'd10, 5'd11, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    checks++;
    if (ctl !== C_NORMAL) begin
      errors++; $display("FAIL no_match: got %b expected %b", ctl, C_NORMAL);
    end
    next_cycle();
    idle();
  endtask

  task automatic test_branch();
    reset_dut();
    set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
    @(posedge clk);
    checks++;
    if (ctl !== C_BRANCH) begin
      errors++; $display("FAIL branch_only: got %b expected %b", ctl, C_BRANCH);
    end
    next_cycle();
    // Branch together with load-use: suppressed, then taken
    set_in(1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0);
    @(posedge clk);
    checks++;
    if (ctl !== C_LU) begin
      errors++; $display("FAIL branch_hazard: got %b expected %b", ctl, C_LU);
    end
    next_cycle();
    @(posedge clk);
    checks++;
    if (ctl !== C_BRANCH) begin
      errors++; $display("FAIL branch_retry: got %b expected %b", ctl, C_BRANCH);
    end
    next_cycle();
    idle();
`ifdef PIPE_CTRL_PERF_EN
    checks++;
    if (stall_cycles !== 32'd1 || flush_count !== 32'd2) begin
      errors++; $display("FAIL branch_perf: got %0d %0d expected 1 2", stall_cycles, flush_count);
    end
`endif
  endtask

  task automatic test_priority();
    reset_dut();
    // Memory wait beats load-use and branch
    set_in(1'b1, 5'd4, 5'd4, 5'd4, 1'b1, 1'b1, 1'b0);
    @(posedge clk);
    checks++;
    if (ctl !== C_FREEZE) begin
      errors++; $display("FAIL prio_mem: got %b expected %b", ctl, C_FREEZE);
    end
    next_cycle();
    pif.mem_ready = 1'b1;
    @(posedge clk);
    checks++;
    if (ctl !== C_NORMAL) begin
      errors++; $display("FAIL prio_ready: got %b expected %b", ctl, C_NORMAL);
    end
    next_cycle();
    idle();
    next_cycle();
  endtask

  task automatic test_mem_wait();
    reset_dut();
    set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
    for (int i = 1; i <= 3; i++) begin
      @(posedge clk);
      checks++;
      if (ctl !== C_FREEZE) begin
        errors++; $display("FAIL mem_freeze_%0d: got %b expected %b", i, ctl, C_FREEZE);
      end
      next_cycle();
      checks++;
      if (state_dbg !== MEM_WAIT || wait_cnt_dbg !== 8'(i)) begin
        errors++;
        $display("FAIL mem_cnt_%0d: got state %0d cnt %0d expected 1 %0d",
                 i, state_dbg, wait_cnt_dbg, i);
      end
    end
    pif.mem_ready = 1'b1;
    @(posedge clk);
    checks++;
    if (ctl !== C_NORMAL) begin
      errors++; $display("FAIL mem_ready_cycle: got %b expected %b", ctl, C_NORMAL);
    end
    next_cycle();
    idle();
    checks++;
    if (state_dbg !== RUN || wait_cnt_dbg !== 8'd0) begin
      errors++;
      $display("FAIL mem_return: got state %0d cnt %0d expected 0 0", state_dbg, wait_cnt_dbg);
    end
`ifdef PIPE_CTRL_PERF_EN
    checks++;
    if (stall_cycles !== 32'd3 || flush_count !== 32'd0) begin
      errors++; $display("FAIL mem_perf: got %0d %0d expected 3 0", stall_cycles, flush_count);
    end
`endif
    @(posedge clk);
    checks++;
    if (ctl !== C_NORMAL) begin
      errors++; $display("FAIL mem_after: got %b expected %b", ctl, C_NORMAL);
    end
    next_cycle();
  endtask

  task automatic test_wait_boundary();
    reset_dut();
    set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
    for (int i = 1; i <= 4; i++) next_cycle();
    checks++;
    if (state_dbg !== MEM_WAIT || wait_cnt_dbg !== 8'd4) begin
      errors++;
      $display("FAIL bound_cnt: got state %0d cnt %0d expected 1 4", state_dbg, wait_cnt_dbg);
    end
    pif.mem_ready = 1'b1;
    @(posedge clk);
    checks++;
    if (ctl !== C_NORMAL) begin
      errors++; $display("FAIL bound_ready: got %b expected %b", ctl, C_NORMAL);
    end
    next_cycle();
    idle();
    checks++;
    if (state_dbg !== RUN || pif.mem_err !== 1'b0) begin
      errors++;
      $display("FAIL bound_no_err: got state %0d err %b expected 0 0", state_dbg, pif.mem_err);
    end
  endtask

  task automatic test_timeout();
    reset_dut();
    set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      next_cycle();
      checks++;
      if (wait_cnt_dbg !== 8'(i) || pif.mem_err !== 1'b0) begin
        errors++;
        $display("FAIL tmo_cnt_%0d: got cnt %0d err %b expected %0d 0", i, wait_cnt_dbg,
                 pif.mem_err, i);
      end
    end
    @(posedge clk);
    checks++;
    if (ctl !== C_FREEZE) begin
      errors++; $display("FAIL tmo_last_wait: got %b expected %b", ctl, C_FREEZE);
    end
    next_cycle();
    checks++;
    if (state_dbg !== ERROR || pif.mem_err !== 1'b1) begin
      errors++;
      $display("FAIL tmo_error: got state %0d err %b expected 2 1", state_dbg, pif.mem_err);
    end
    // ERROR ignores a late ready and a dropped request
    set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
    @(posedge clk);
    checks++;
    if (ctl !== C_HALT) begin
      errors++; $display("FAIL tmo_halt: got %b expected %b", ctl, C_HALT);
    end
    next_cycle();
    next_cycle();
    checks++;
    if (state_dbg !== ERROR || pif.mem_err !== 1'b1) begin
      errors++;
      $display("FAIL tmo_sticky: got state %0d err %b expected 2 1", state_dbg, pif.mem_err);
    end
    idle();
    rst_n = 1'b0;
    @(posedge clk);
    checks++;
    if (ctl !== C_HALT) begin
      errors++; $display("FAIL tmo_reset_out: got %b expected %b", ctl, C_HALT);
    end
    next_cycle();
    rst_n = 1'b1;
    checks++;
    if (state_dbg !== RUN || pif.mem_err !== 1'b0 || wait_cnt_dbg !== 8'd0) begin
      errors++;
      $display("FAIL tmo_recover: got state %0d err %b cnt %0d expected 0 0 0",
               state_dbg, pif.mem_err, wait_cnt_dbg);
    end
`ifdef PIPE_CTRL_PERF_EN
    checks++;
    if (stall_cycles !== 32'd0 || flush_count !== 32'd0) begin
      errors++; $display("FAIL tmo_perf_clear: got %0d %0d expected 0 0", stall_cycles, flush_count);
    end
`endif
    @(posedge clk);
    checks++;
    if (ctl !== C_NORMAL) begin
      errors++; $display("FAIL tmo_run: got %b expected %b", ctl, C_NORMAL);
    end
    next_cycle();
  endtask

  // Test sequence and final report
  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    idle();
    test_reset();
    test_load_use();
    test_no_hazard();
    test_branch();
    test_priority();
    test_mem_wait();
    test_wait_boundary();
    test_timeout();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
